// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition timing generator: FSM state codes, sampling
// constants and range codes.
package acq_pkg;

  localparam int unsigned SAMPLES_PER_PERIOD = 32;
  localparam int unsigned SAMPLE_SHIFT       = 5;
  localparam int unsigned WD_PERIODS         = 40;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_LOCK       = 3'd1;
  localparam state_t ST_DIAP_START = 3'd2;
  localparam state_t ST_DIAP_WAIT  = 3'd3;
  localparam state_t ST_RANGE_EVAL = 3'd4;
  localparam state_t ST_RES_START  = 3'd5;
  localparam state_t ST_RES_WAIT   = 3'd6;
  localparam state_t ST_PUBLISH    = 3'd7;

  localparam logic [1:0] RANGE_LOW  = 2'd0;
  localparam logic [1:0] RANGE_MID  = 2'd1;
  localparam logic [1:0] RANGE_HIGH = 2'd2;

  function automatic logic [1:0] range_classify(input logic [31:0] m,
                                                input logic [31:0] lo_thr,
                                                input logic [31:0] hi_thr);
    if (m >= hi_thr) return RANGE_HIGH;
    if (m >= lo_thr) return RANGE_MID;
    return RANGE_LOW;
  endfunction

endpackage

// File: rtl/period_tracker.sv
// Synchronises period_sync, measures the sync period and paces 32 sample pulses per period.
module period_tracker
  import acq_pkg::*;
#(
  parameter int unsigned PERIOD_CNT_WIDTH = 20,
  parameter int unsigned MIN_PERIOD       = 1024,
  parameter int unsigned MAX_PERIOD       = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       period_sync,
  output logic       sync_edge,
  output logic       sample_pulse,
  output logic [4:0] sample_idx,
  output logic       period_ok
);

  localparam int unsigned IW = PERIOD_CNT_WIDTH - SAMPLE_SHIFT;
  localparam logic [PERIOD_CNT_WIDTH-1:0] MinP = PERIOD_CNT_WIDTH'(MIN_PERIOD);
  localparam logic [PERIOD_CNT_WIDTH-1:0] MaxP = PERIOD_CNT_WIDTH'(MAX_PERIOD);
  localparam logic [4:0] LastIdx = 5'(SAMPLES_PER_PERIOD - 1);

  logic                        r_sync_meta, r_sync_sync, r_sync_prev, r_sync_edge;
  logic [PERIOD_CNT_WIDTH-1:0] r_cnt;
  logic                        r_seen_edge;
  logic [1:0]                  r_valid_cnt;
  logic [IW-1:0]               r_interval, r_tmr;
  logic [4:0]                  r_idx;
  logic                        r_active;

  logic [PERIOD_CNT_WIDTH-1:0] w_measured;
  logic                        w_in_range, w_timeout;

  assign w_measured = r_cnt + 1'b1;
  assign w_in_range = (w_measured >= MinP) && (w_measured <= MaxP);
  assign w_timeout  = !r_sync_edge && (r_cnt == MaxP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_meta <= 1'b0;
      r_sync_sync <= 1'b0;
      r_sync_prev <= 1'b0;
      r_sync_edge <= 1'b0;
    end else begin
      r_sync_meta <= period_sync;
      r_sync_sync <= r_sync_meta;
      r_sync_prev <= r_sync_sync;
      r_sync_edge <= r_sync_sync & ~r_sync_prev;
    end
  end

  // The first edge after reset or a timeout only opens a measurement window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_seen_edge <= 1'b0;
      r_valid_cnt <= 2'd0;
      r_interval  <= '0;
    end else if (r_sync_edge) begin
      r_cnt       <= '0;
      r_seen_edge <= 1'b1;
      if (r_seen_edge && w_in_range) begin
        if (r_valid_cnt != 2'd2) r_valid_cnt <= r_valid_cnt + 2'd1;
        r_interval <= w_measured[PERIOD_CNT_WIDTH-1:SAMPLE_SHIFT];
      end else begin
        r_valid_cnt <= 2'd0;
      end
    end else if (w_timeout) begin
      r_cnt       <= r_cnt + 1'b1;
      r_seen_edge <= 1'b0;
      r_valid_cnt <= 2'd0;
    end else if (r_cnt < MaxP) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr    <= '0;
      r_idx    <= 5'd0;
      r_active <= 1'b0;
    end else if (r_sync_edge) begin
      r_tmr    <= '0;
      r_idx    <= 5'd0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_tmr == r_interval - 1'b1) begin
        r_tmr <= '0;
        if (r_idx == LastIdx) r_active <= 1'b0;
        else                  r_idx    <= r_idx + 5'd1;
      end else begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

  assign sync_edge    = r_sync_edge;
  assign sample_pulse = r_active && (r_tmr == '0);
  assign sample_idx   = r_idx;
  assign period_ok    = (r_valid_cnt == 2'd2);

endmodule

// File: rtl/acq_timing_gen.sv
// Acquisition timing generator: locks to period_sync, paces ADC samples and sequences
// range/result conversion cycles. Define ACQ_WATCHDOG_EN to add the wait-state watchdog.
module acq_timing_gen
  import acq_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH       = 18,
  parameter int unsigned           PERIOD_CNT_WIDTH = 20,
  parameter int unsigned           MIN_PERIOD       = 1024,
  parameter int unsigned           MAX_PERIOD       = 1000000,
  parameter logic [DATA_WIDTH-1:0] RANGE_LO_THR     = 18'h08000,
  parameter logic [DATA_WIDTH-1:0] RANGE_HI_THR     = 18'h20000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  period_sync,
  input  logic                  adc_complete,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  output logic                  sample_adc,
  output logic                  start_cycle_conv,
  output logic                  read_diapason,
  output logic                  halfcycle,
  output logic [1:0]            range_code,
  output logic [DATA_WIDTH-1:0] result_1,
  output logic [DATA_WIDTH-1:0] result_2,
  output logic                  result_valid,
  output logic                  sync_lost
);

  logic       w_sync_edge, w_sample_pulse, w_period_ok;
  logic [4:0] w_sample_idx;

  period_tracker #(
    .PERIOD_CNT_WIDTH(PERIOD_CNT_WIDTH),
    .MIN_PERIOD      (MIN_PERIOD),
    .MAX_PERIOD      (MAX_PERIOD)
  ) u_period_tracker (
    .clk         (clk),
    .rst         (rst),
    .period_sync (period_sync),
    .sync_edge   (w_sync_edge),
    .sample_pulse(w_sample_pulse),
    .sample_idx  (w_sample_idx),
    .period_ok   (w_period_ok)
  );

  state_t                r_state, w_state_next;
  logic                  r_sample_adc, r_sample_ext;
  logic                  r_start_conv, r_conv_ext;
  logic                  r_read_diapason;
  logic [1:0]            r_range_code;
  logic [DATA_WIDTH-1:0] r_result_1, r_result_2;
  logic                  r_result_valid;
  logic                  w_in_acq, w_in_wait, w_launch, w_abort, w_wd_fire;
  logic [DATA_WIDTH-1:0] w_max;

  assign w_in_acq  = (r_state >= ST_DIAP_START) && (r_state <= ST_RES_WAIT);
  assign w_in_wait = (r_state == ST_DIAP_WAIT) || (r_state == ST_RES_WAIT);
  assign w_max     = (data_in_1 >= data_in_2) ? data_in_1 : data_in_2;
  assign w_abort   = w_in_acq && (!w_period_ok || w_wd_fire);

`ifdef ACQ_WATCHDOG_EN
  logic [5:0] r_wd_cnt;
  logic       r_wd_pulse;

  // Fires on the sync edge that ends the 41st full period spent in a wait state.
  assign w_wd_fire = w_in_wait && w_sync_edge && (r_wd_cnt == 6'(WD_PERIODS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt   <= 6'd0;
      r_wd_pulse <= 1'b0;
    end else begin
      r_wd_pulse <= w_wd_fire;
      if (!w_in_wait || w_wd_fire) r_wd_cnt <= 6'd0;
      else if (w_sync_edge)        r_wd_cnt <= r_wd_cnt + 6'd1;
    end
  end

  assign sync_lost = ~w_period_ok | r_wd_pulse;
`else
  assign w_wd_fire = 1'b0;
  assign sync_lost = ~w_period_ok;
`endif

  // Conversions launch only on a sync edge, and only once read_diapason has settled.
  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    case (r_state)
      ST_IDLE:       w_state_next = ST_LOCK;
      ST_LOCK:       if (w_period_ok) w_state_next = ST_DIAP_START;
      ST_DIAP_START: begin
        if (w_sync_edge && r_read_diapason) begin
          w_launch     = 1'b1;
          w_state_next = ST_DIAP_WAIT;
        end
      end
      ST_DIAP_WAIT:  if (adc_complete) w_state_next = ST_RANGE_EVAL;
      ST_RANGE_EVAL: w_state_next = ST_RES_START;
      ST_RES_START: begin
        if (w_sync_edge && !r_read_diapason) begin
          w_launch     = 1'b1;
          w_state_next = ST_RES_WAIT;
        end
      end
      ST_RES_WAIT:   if (adc_complete) w_state_next = ST_PUBLISH;
      ST_PUBLISH:    w_state_next = ST_DIAP_START;
      default:       w_state_next = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_next = ST_LOCK;
      w_launch     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_sample_adc    <= 1'b0;
      r_sample_ext    <= 1'b0;
      r_start_conv    <= 1'b0;
      r_conv_ext      <= 1'b0;
      r_read_diapason <= 1'b0;
      r_range_code    <= RANGE_LOW;
      r_result_1      <= '0;
      r_result_2      <= '0;
      r_result_valid  <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (!w_period_ok) begin
        r_sample_adc <= 1'b0;
        r_sample_ext <= 1'b0;
      end else if (w_sample_pulse) begin
        r_sample_adc <= 1'b1;
        r_sample_ext <= 1'b1;
      end else if (r_sample_ext) begin
        r_sample_ext <= 1'b0;
      end else begin
        r_sample_adc <= 1'b0;
      end

      if (w_launch) begin
        r_start_conv <= 1'b1;
        r_conv_ext   <= 1'b1;
      end else if (r_conv_ext) begin
        r_conv_ext <= 1'b0;
      end else begin
        r_start_conv <= 1'b0;
      end

      if (w_abort)                       r_read_diapason <= 1'b0;
      else if (r_state == ST_DIAP_START) r_read_diapason <= 1'b1;
      else if (r_state == ST_RES_START)  r_read_diapason <= 1'b0;

      if (r_state == ST_RANGE_EVAL) begin
        r_range_code <= range_classify(32'(w_max), 32'(RANGE_LO_THR), 32'(RANGE_HI_THR));
      end

      r_result_valid <= (r_state == ST_PUBLISH);
      if (r_state == ST_PUBLISH) begin
        r_result_1 <= data_in_1;
        r_result_2 <= data_in_2;
      end
    end
  end

  assign sample_adc       = r_sample_adc;
  assign start_cycle_conv = r_start_conv;
  assign read_diapason    = r_read_diapason;
  assign halfcycle        = w_period_ok && (w_sample_idx >= 5'd16);
  assign range_code       = r_range_code;
  assign result_1         = r_result_1;
  assign result_2         = r_result_2;
  assign result_valid     = r_result_valid;

endmodule

// File: tb/tb_acq_timing_gen.sv
// Directed bench for acq_timing_gen with a shortened sync period (640 clocks, interval 20).
module tb_acq_timing_gen;

  localparam int unsigned DW   = 18;
  localparam int unsigned PCW  = 12;
  localparam int unsigned MINP = 256;
  localparam int unsigned MAXP = 2000;
  localparam int          PER  = 640;
  localparam int          INTV = PER / 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          period_sync;
  logic          adc_complete;
  logic [DW-1:0] data_in_1, data_in_2;
  logic          sample_adc, start_cycle_conv, read_diapason, halfcycle;
  logic [1:0]    range_code;
  logic [DW-1:0] result_1, result_2;
  logic          result_valid, sync_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int sync_period = 0;

  always #5 clk = ~clk;

  acq_timing_gen #(
    .DATA_WIDTH      (DW),
    .PERIOD_CNT_WIDTH(PCW),
    .MIN_PERIOD      (MINP),
    .MAX_PERIOD      (MAXP),
    .RANGE_LO_THR    (18'h08000),
    .RANGE_HI_THR    (18'h20000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .period_sync     (period_sync),
    .adc_complete    (adc_complete),
    .data_in_1       (data_in_1),
    .data_in_2       (data_in_2),
    .sample_adc      (sample_adc),
    .start_cycle_conv(start_cycle_conv),
    .read_diapason   (read_diapason),
    .halfcycle       (halfcycle),
    .range_code      (range_code),
    .result_1        (result_1),
    .result_2        (result_2),
    .result_valid    (result_valid),
    .sync_lost       (sync_lost)
  );

  // Sync source: rising edges exactly sync_period clocks apart; 0 stops it.
  initial begin
    period_sync = 1'b0;
    forever begin
      if (sync_period != 0) begin
        period_sync = 1'b1;
        repeat (8) @(negedge clk);
        period_sync = 1'b0;
        repeat (sync_period - 8) @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
  end

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [1:0]    exp_range;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not seen within its cycle budget", name);
  endtask

  task automatic wait_lock(input int limit, output int cyc, output int pre_samples);
    cyc = 0;
    pre_samples = 0;
    while (sync_lost !== 1'b0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (sync_lost === 1'b1 && sample_adc === 1'b1) pre_samples++;
    end
    if (sync_lost !== 1'b0) fail_now("lock");
  endtask

  task automatic wait_start(input logic exp_diap, input string tag);
    int k = 0;
    while (start_cycle_conv !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (start_cycle_conv !== 1'b1) begin
      fail_now({tag, " start_cycle_conv"});
    end else begin
      check({tag, " read_diapason at start"}, 64'(read_diapason), 64'(exp_diap));
      @(negedge clk);
      check({tag, " start_cycle_conv cycle 2"}, 64'(start_cycle_conv), 64'd1);
      @(negedge clk);
      check({tag, " start_cycle_conv cycle 3"}, 64'(start_cycle_conv), 64'd0);
    end
  endtask

  task automatic adc_done(input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    @(negedge clk);
    data_in_1    = d1;
    data_in_2    = d2;
    adc_complete = 1'b1;
    @(negedge clk);
    adc_complete = 1'b0;
  endtask

  task automatic wait_valid(input logic [DW-1:0] e1, input logic [DW-1:0] e2, input string tag);
    int k = 0;
    while (result_valid !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (result_valid !== 1'b1) begin
      fail_now({tag, " result_valid"});
    end else begin
      check({tag, " result_1"}, 64'(result_1), 64'(e1));
      check({tag, " result_2"}, 64'(result_2), 64'(e2));
      @(negedge clk);
      check({tag, " result_valid width"}, 64'(result_valid), 64'd0);
    end
  endtask

  task automatic count_high(input int n, output int highs, output int valids);
    highs  = 0;
    valids = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (sample_adc === 1'b1) highs++;
      if (result_valid === 1'b1) valids++;
    end
  endtask

  initial begin
    int cyc, pre, highs, valids, rises, hc_rises, bad_gap, last_rise;
    logic prev;

    vecs[0] = '{18'h21000, 18'h00100, 2'd2, 18'h12345, 18'h00ABC};
    vecs[1] = '{18'h00100, 18'h07FFF, 2'd0, 18'h3FFFF, 18'h00000};
    vecs[2] = '{18'h08000, 18'h00000, 2'd1, 18'h00001, 18'h3FFFE};
    vecs[3] = '{18'h00000, 18'h1FFFF, 2'd1, 18'h2AAAA, 18'h15555};
    vecs[4] = '{18'h20000, 18'h1FFFF, 2'd2, 18'h0F0F0, 18'h30303};
    vecs[5] = '{18'h07FFF, 18'h07FFF, 2'd0, 18'h1C0DE, 18'h0BEEF};

    rst = 1'b1;
    adc_complete = 1'b0;
    data_in_1 = '0;
    data_in_2 = '0;
    repeat (3) @(negedge clk);
    check("reset sample_adc",       64'(sample_adc),       64'd0);
    check("reset start_cycle_conv", 64'(start_cycle_conv), 64'd0);
    check("reset read_diapason",    64'(read_diapason),    64'd0);
    check("reset halfcycle",        64'(halfcycle),        64'd0);
    check("reset range_code",       64'(range_code),       64'd0);
    check("reset result_1",         64'(result_1),         64'd0);
    check("reset result_valid",     64'(result_valid),     64'd0);
    check("reset sync_lost",        64'(sync_lost),        64'd1);

    rst = 1'b0;
    sync_period = PER;
    wait_lock(4000, cyc, pre);
    check("no sample_adc before lock", 64'(pre), 64'd0);

    wait_start(1'b1, "first diap");

    // Two full periods of sample pacing while the FSM sits in DIAP_WAIT.
    rises = 0; hc_rises = 0; bad_gap = 0; highs = 0; last_rise = -1;
    prev = sample_adc;
    for (int c = 0; c < 2 * PER; c++) begin
      @(negedge clk);
      if (sample_adc === 1'b1) highs++;
      if (sample_adc === 1'b1 && prev === 1'b0) begin
        rises++;
        if (halfcycle === 1'b1) hc_rises++;
        if (last_rise >= 0 && (c - last_rise) != INTV) bad_gap++;
        last_rise = c;
      end
      prev = sample_adc;
    end
    check("sample pulses in 2 periods", 64'(rises),    64'd64);
    check("sample_adc high cycles",     64'(highs),    64'd128);
    check("sample interval errors",     64'(bad_gap),  64'd0);
    check("halfcycle pulses",           64'(hc_rises), 64'd32);

    for (int i = 0; i < 6; i++) begin
      adc_done(vecs[i].d1, vecs[i].d2);
      wait_start(1'b0, $sformatf("vec%0d res", i));
      check($sformatf("vec%0d range_code", i), 64'(range_code), 64'(vecs[i].exp_range));
      adc_done(vecs[i].r1, vecs[i].r2);
      wait_valid(vecs[i].r1, vecs[i].r2, $sformatf("vec%0d", i));
      wait_start(1'b1, $sformatf("vec%0d next diap", i));
    end

    // Period below MIN_PERIOD: lock drops and pacing stops; results are kept.
    sync_period = 200;
    cyc = 0;
    while (sync_lost !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (sync_lost !== 1'b1) fail_now("short period sync_lost");
    repeat (4) @(negedge clk);
    count_high(1500, highs, valids);
    check("short period sample_adc", 64'(highs), 64'd0);
    check("short period sync_lost held", 64'(sync_lost), 64'd1);
    check("short period result_1 kept", 64'(result_1), 64'(vecs[5].r1));
    check("short period range kept", 64'(range_code), 64'(vecs[5].exp_range));

    sync_period = PER;
    wait_lock(3 * PER + 100, cyc, pre);
    check("relock after short period", 64'(cyc >= 2 * PER && cyc <= 3 * PER), 64'd1);

    // Sync stops during RES_WAIT.
    wait_start(1'b1, "stop diap");
    adc_done(vecs[0].d1, vecs[0].d2);
    wait_start(1'b0, "stop res");
    sync_period = 0;
    cyc = 0;
    while (sync_lost !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (sync_lost !== 1'b1) fail_now("sync stop sync_lost");
    repeat (4) @(negedge clk);
    count_high(300, highs, valids);
    check("sync stop sample_adc", 64'(highs), 64'd0);
    check("sync stop result_1 kept", 64'(result_1), 64'(vecs[5].r1));
    check("sync stop result_2 kept", 64'(result_2), 64'(vecs[5].r2));
    check("sync stop range kept", 64'(range_code), 64'd2);
    adc_done(18'h11111, 18'h22222);
    count_high(10, highs, valids);
    check("stray adc_complete ignored", 64'(valids), 64'd0);
    check("stray adc_complete result_1", 64'(result_1), 64'(vecs[5].r1));

    sync_period = PER;
    wait_lock(3 * PER + 100, cyc, pre);
    check("relock after sync stop", 64'(cyc >= 2 * PER && cyc <= 3 * PER), 64'd1);

    // Reset in RES_WAIT.
    wait_start(1'b1, "rst diap");
    adc_done(vecs[4].d1, vecs[4].d2);
    wait_start(1'b0, "rst res");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst sample_adc",       64'(sample_adc),       64'd0);
    check("mid rst start_cycle_conv", 64'(start_cycle_conv), 64'd0);
    check("mid rst halfcycle",        64'(halfcycle),        64'd0);
    check("mid rst range_code",       64'(range_code),       64'd0);
    check("mid rst result_1",         64'(result_1),         64'd0);
    check("mid rst result_2",         64'(result_2),         64'd0);
    check("mid rst sync_lost",        64'(sync_lost),        64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    adc_done(18'h12345, 18'h00ABC);
    count_high(20, highs, valids);
    check("no result_valid after rst", 64'(valids), 64'd0);

`ifdef ACQ_WATCHDOG_EN
    wait_lock(3 * PER + 100, cyc, pre);
    wait_start(1'b1, "wd diap");
    cyc = 0;
    while (sync_lost !== 1'b1 && cyc < 42 * PER) begin
      @(negedge clk);
      cyc++;
    end
    if (sync_lost !== 1'b1) begin
      fail_now("watchdog sync_lost");
    end else begin
      check("watchdog delay", 64'(cyc >= 40 * PER && cyc <= 42 * PER), 64'd1);
      @(negedge clk);
      check("watchdog pulse width", 64'(sync_lost), 64'd0);
      wait_start(1'b1, "wd relaunch");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acq_timing_gen.md
ACQ_TIMING_GEN -- requirements
Module: acq_timing_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18: width of each channel result.
REQ-002 SHALL have parameter PERIOD_CNT_WIDTH, default 20: width of the period counter.
REQ-003 SHALL have parameter MIN_PERIOD, default 1024: smallest valid period in clocks.
REQ-004 SHALL have parameter MAX_PERIOD, default 1000000: largest valid period in clocks.
REQ-005 SHALL have parameter RANGE_LO_THR, default 18'h08000: lower range threshold.
REQ-006 SHALL have parameter RANGE_HI_THR, default 18'h20000: upper range threshold.
REQ-007 SHALL have port clk, input, 1: the single clock.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have port period_sync, input, 1: asynchronous external period reference, rising edge marks period start.
REQ-010 SHALL have port adc_complete, input, 1: one-cycle done pulse from the ADC read stage.
REQ-011 SHALL have ports data_in_1 and data_in_2, input, DATA_WIDTH each: ADC read stage results.
REQ-012 SHALL have port sample_adc, output, 1: per-sample conversion request.
REQ-013 SHALL have port start_cycle_conv, output, 1: start of an accumulation cycle.
REQ-014 SHALL have port read_diapason, output, 1: 1 selects a range cycle, 0 selects a result cycle.
REQ-015 SHALL have port halfcycle, output, 1: high during sample indices 16..31 of a period.
REQ-016 SHALL have port range_code, output, 2: latched range decision.
REQ-017 SHALL have ports result_1 and result_2, output, DATA_WIDTH each: published results.
REQ-018 SHALL have port result_valid, output, 1: one-cycle publish strobe.
REQ-019 SHALL have port sync_lost, output, 1: period out of bounds or absent.

Function
REQ-020 SHALL synchronise period_sync through 2 flops and detect rising edges, giving 3 cycles latency.
REQ-021 SHALL count clocks between consecutive sync edges; sample interval = period >> 5; the remainder SHALL be discarded.
REQ-022 SHALL restart the sample timer and sample index 0 on every sync edge, and SHALL emit at most 32 sample_adc pulses per period, each 2 cycles high.
REQ-023 SHALL assert sync_lost when the period is < MIN_PERIOD, or when the counter exceeds MAX_PERIOD without an edge; sample_adc SHALL then be held low until 2 consecutive valid periods are seen.
REQ-024 SHALL implement FSM states IDLE, LOCK, DIAP_START, DIAP_WAIT, RANGE_EVAL, RES_START, RES_WAIT, PUBLISH.
REQ-025 IDLE->LOCK after reset; LOCK->DIAP_START after 2 consecutive valid periods.
REQ-026 DIAP_START SHALL set read_diapason=1 and, one cycle later, drive start_cycle_conv high for 2 cycles, aligned to a sync edge; then go to DIAP_WAIT.
REQ-027 DIAP_WAIT->RANGE_EVAL on adc_complete; RANGE_EVAL: m = max(data_in_1, data_in_2); range_code = 2 if m >= RANGE_HI_THR, 1 if m >= RANGE_LO_THR, else 0.
REQ-028 RES_START SHALL clear read_diapason and then pulse start_cycle_conv as in REQ-026; RES_WAIT->PUBLISH on adc_complete.
REQ-029 PUBLISH SHALL latch data_in_1 and data_in_2 into result_1 and result_2, pulse result_valid for 1 cycle, and return to DIAP_START.
REQ-030 read_diapason SHALL stay stable from start_cycle_conv until adc_complete.
REQ-031 sync_lost in any DIAP or RES state SHALL abort to LOCK; the previous results and range_code SHALL be kept.
REQ-032 An adc_complete outside DIAP_WAIT or RES_WAIT SHALL be ignored.

Reset
REQ-033 While rst is high: state IDLE, all counters 0, all outputs 0, sync_lost 1.
REQ-034 Reset mid-cycle SHALL abort immediately, with no result_valid pulse.

Configuration
REQ-035 With ACQ_WATCHDOG_EN defined, a wait state lasting more than 40 sync periods SHALL pulse sync_lost for 1 cycle and go to LOCK.
REQ-036 Without ACQ_WATCHDOG_EN, the wait states SHALL wait indefinitely and the watchdog counter SHALL be absent.

Structure
REQ-037 The FSM state enum, SAMPLES_PER_PERIOD=32, SAMPLE_SHIFT=5 and the range codes SHALL live in shared package acq_pkg.
REQ-038 The sync synchroniser, period counter and sample timer SHALL form sub-module period_tracker (outputs: sync_edge, sample_pulse, sample_idx, period_ok).

Verification
REQ-039 Sync period 64000 clocks -> after lock, sample_adc pulses every 2000 clocks, 32 per period, halfcycle rises at index 16.
REQ-040 Range cycle: data_in_1=18'h21000, data_in_2=18'h00100 on adc_complete -> range_code=2; then start_cycle_conv is seen with read_diapason=0.
REQ-041 Result cycle: data_in=18'h12345 and 18'h00ABC on adc_complete -> result_1=18'h12345, result_2=18'h00ABC, result_valid high exactly 1 cycle.
REQ-042 Sync stopped for longer than MAX_PERIOD during RES_WAIT -> sync_lost=1, sample_adc held low, previous results kept; sync restored -> relock after 2 periods.
REQ-043 Period 500 clocks (< MIN_PERIOD) -> no sample_adc pulses and sync_lost=1.
REQ-044 rst pulsed during RES_WAIT -> all outputs 0, no result_valid; with ACQ_WATCHDOG_EN, no adc_complete for 40 periods -> sync_lost pulse and FSM in LOCK.
